lpc_autocorr: RTL and testbench
===============================

# lpc_autocorr

Windowing and autocorrelation stage of the G.729 encoder LPC analysis. It sits directly downstream of the LPC memory controller (`LPC_Mem_Ctrl`). On each `frame_done`, it reads the 240-sample analysis buffer through the controller's `Out_Count`/`Out_Sample` port and applies the analysis window supplied by an external window ROM. It then computes autocorrelations r[0..10] with ITU fixed-point semantics and writes them out for the Levinson-Durbin stage.

## Interface
- `N_SAMP`, default 240: analysis window length.
- `N_LAG`, default 10: highest lag computed; r[0..N_LAG] are produced.
- `clock`  in  1: rising-edge clock, the single clock domain.
- `reset`  in  1: asynchronous, active-low reset.
- `start`  in  1: one-cycle pulse, connected to `frame_done` of the memory controller.
- `Mem_Count`  out  8: sample index driven to the controller's `Out_Count`.
- `Mem_Sample`  in  16: controller `Out_Sample`; valid one cycle after `Mem_Count`.
- `Win_Addr`  out  8: window ROM address.
- `Win_Coef`  in  16: Q15 window coefficient; valid one cycle after `Win_Addr`.
- `Acf_Addr`  out  4: lag index k of the current result.
- `Acf_Data`  out  32: r[k].
- `Acf_Write`  out  1: one-cycle strobe qualifying `Acf_Addr`/`Acf_Data`.
- `busy`  out  1: high from the first cycle after an accepted `start` until `done`.
- `done`  out  1: one-cycle pulse after r[N_LAG] is written.

## Operation
- Internal storage: y[0..239] register array, 16 bits each.
- **State IDLE**
  - Waits for `start`.
  - `start` is ignored in every other state.
- **State WIN**
  - Drives `Mem_Count` = `Win_Addr` = n for n = 0..239.
  - One cycle later, captures y[n] = mult_r(Mem_Sample, Win_Coef) = (x·w + 0x4000) >>> 15.
  - Saturates only for -32768·-32768, giving 0x7FFF.
  - After y[239] is stored, moves to ACF with k = 0.
- **State ACF**
  - For n = k..239: acc = L_mac(acc, y[n], y[n-k]), i.e. acc + 2·y[n]·y[n-k].
  - Saturates to 0x7FFFFFFF / 0x80000000 at every step, and stays saturated once it hits a limit.
  - acc is preloaded with 1 for k = 0 and with 0 for k > 0.
- **State WR**
  - Asserts `Acf_Write` with `Acf_Addr` = k and `Acf_Data` = acc.
  - If k < N_LAG: k increments and the block returns to ACF.
  - Otherwise: goes to DONE.
- **State DONE**
  - `done` = 1 for one cycle, then IDLE.
- The memory controller may overwrite its buffer after WIN completes. The block never reads it again within the frame.
- Arithmetic: 16×16 signed products in 32-bit; the doubled product and accumulate run in 33-bit and are then clamped.

## Timing
- Reset values:
  - FSM = IDLE, k = 0, acc = 0.
  - `Mem_Count` = `Win_Addr` = 0, `Acf_Addr` = 0, `Acf_Data` = 0.
  - `Acf_Write` = `busy` = `done` = 0.
  - y[] contents are don't-care.
- Cycle 0: `start` is sampled high.
- WIN occupies cycles 1..241: 240 address cycles plus 1 capture flush.
- ACF for lag k takes 240−k cycles; WR takes 1 cycle per lag.
- Lags 0..10 therefore take 2585 + 11 = 2596 cycles, occupying cycles 242..2837.
- `done` pulses at cycle 2838, and `busy` falls in that same cycle.
- `Acf_Write` pulses exactly 11 times per frame, with `Acf_Addr` strictly 0..10 ascending.
- A `start` that arrives in the same cycle as `done` is ignored. The next `start` is accepted from IDLE.
- `reset` asserted mid-frame: all outputs return to reset values asynchronously. No partial `Acf_Write` or `done` follows.

## Test plan
- All-zero samples, window 0x7FFF:
  - r[0] = 0x00000001 and r[1..10] = 0.
  - `done` pulses at cycle 2838.
- Constant samples 0x0100, window 0x7FFF:
  - y = 256, so r[k] = (240−k)·131072 (+1 for k = 0).
  - r[0] = 0x01E00001, r[10] = 0x01CC0000.
- Impulse: sample[0] = 0x4000, all others 0, window 0x7FFF:
  - r[0] = 0x20000001 and r[1..10] = 0.
- Saturation: samples 0x7FFF, window 0x7FFF:
  - y = 0x7FFE, and every r[k] = 0x7FFFFFFF.
- Protocol:
  - Pulse `start` again at cycle 100 → ignored: `Acf_Write` count stays 11 and `done` stays at cycle 2838.
  - Back-to-back frames → second frame results are identical to an isolated run.
- Reset mid-ACF at cycle 1000:
  - All outputs go to 0 immediately, and no `Acf_Write`/`done` follows.
  - A subsequent `start` produces a correct full frame.

Source files
------------

// File: rtl/lpc_autocorr_if.sv
// Sample/window fetch and autocorrelation result bus of the LPC autocorrelation stage.
// The master side is lpc_autocorr; the slave side is the memory controller, window ROM and result sink.
interface lpc_autocorr_if;
  logic [7:0]  Mem_Count;
  logic [15:0] Mem_Sample;
  logic [7:0]  Win_Addr;
  logic [15:0] Win_Coef;
  logic [3:0]  Acf_Addr;
  logic [31:0] Acf_Data;
  logic        Acf_Write;

  modport master (
    output Mem_Count, Win_Addr, Acf_Addr, Acf_Data, Acf_Write,
    input  Mem_Sample, Win_Coef
  );

  modport slave (
    input  Mem_Count, Win_Addr, Acf_Addr, Acf_Data, Acf_Write,
    output Mem_Sample, Win_Coef
  );
endinterface

// File: rtl/lpc_autocorr.sv
// G.729 LPC windowing and autocorrelation: y[n] = mult_r(x[n], w[n]), then r[k] = sum of L_mac(y[n], y[n-k]).
// Each lag uses one MAC per cycle. Results stream out on Acf_Write, lag 0 first.
module lpc_autocorr #(
  parameter int N_SAMP = 240,
  parameter int N_LAG  = 10
) (
  input  logic           clock,
  input  logic           reset,
  input  logic           start,
  lpc_autocorr_if.master bus,
  output logic           busy,
  output logic           done
);
  typedef enum logic [2:0] {IDLE, WIN, ACF, WR, DONE} state_t;

  localparam logic [7:0] NS   = 8'(N_SAMP);
  localparam logic [7:0] LAST = 8'(N_SAMP - 1);
  localparam logic [3:0] KMAX = 4'(N_LAG);

  state_t      state, next_state;
  logic [7:0]  idx, cap_idx;
  logic        cap_valid;
  logic [3:0]  k;
  logic [31:0] acc;
  logic        sat;
  logic [15:0] y [N_SAMP];

  logic signed [31:0] prod_w, rnd, prod_a;
  logic signed [32:0] sum;
  logic [15:0]        y_new;
  logic [31:0]        mac_next;
  logic               mac_sat;

  // mult_r: the only overflowing case is -1 * -1 in Q15
  always_comb begin
    prod_w = $signed(bus.Mem_Sample) * $signed(bus.Win_Coef);
    rnd    = prod_w + 32'sh0000_4000;
    if (bus.Mem_Sample == 16'h8000 && bus.Win_Coef == 16'h8000)
      y_new = 16'h7FFF;
    else
      y_new = rnd[30:15];
  end

  always_comb begin
    prod_a  = $signed(y[idx]) * $signed(y[idx - {4'b0, k}]);
    sum     = $signed({acc[31], acc}) + $signed({prod_a, 1'b0});
    mac_sat = (sum[32] != sum[31]);
    if (!mac_sat)
      mac_next = sum[31:0];
    else if (sum[32])
      mac_next = 32'h8000_0000;
    else
      mac_next = 32'h7FFF_FFFF;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset)
      state <= IDLE;
    else
      state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE: if (start) next_state = WIN;
      WIN:  if (cap_valid && cap_idx == LAST) next_state = ACF;
      ACF:  if (idx == LAST) next_state = WR;
      WR:   next_state = (k == KMAX) ? DONE : ACF;
      DONE: next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    bus.Mem_Count = (state == WIN) ? idx : 8'd0;
    bus.Win_Addr  = (state == WIN) ? idx : 8'd0;
    bus.Acf_Write = (state == WR);
    bus.Acf_Addr  = (state == WR) ? k : 4'd0;
    bus.Acf_Data  = (state == WR) ? acc : 32'd0;
    busy          = (state == WIN) || (state == ACF) || (state == WR);
    done          = (state == DONE);
  end

  // Capture lags the address by one cycle; each lag restarts at n = k with acc preloaded
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      idx       <= 8'd0;
      cap_idx   <= 8'd0;
      cap_valid <= 1'b0;
      k         <= 4'd0;
      acc       <= 32'd0;
      sat       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          idx       <= 8'd0;
          cap_valid <= 1'b0;
          k         <= 4'd0;
        end
        WIN: begin
          if (idx != NS) idx <= idx + 8'd1;
          cap_valid <= (idx != NS);
          cap_idx   <= idx;
          if (cap_valid && cap_idx == LAST) begin
            idx <= 8'd0;
            acc <= 32'd1;
            sat <= 1'b0;
          end
        end
        ACF: begin
          if (!sat) begin
            acc <= mac_next;
            sat <= mac_sat;
          end
          idx <= idx + 8'd1;
        end
        WR: begin
          if (k != KMAX) begin
            k   <= k + 4'd1;
            idx <= {4'b0, k} + 8'd1;
            acc <= 32'd0;
            sat <= 1'b0;
          end
        end
        DONE: begin
          k   <= 4'd0;
          idx <= 8'd0;
          acc <= 32'd0;
          sat <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (state == WIN && cap_valid)
      y[cap_idx] <= y_new;
  end
endmodule

// File: tb/tb_lpc_autocorr.sv
// Self-checking bench for lpc_autocorr: directed and random frames against an arithmetic reference model.
module tb_lpc_autocorr;
  logic clock = 1'b0;
  logic reset = 1'b0;
  logic start = 1'b0;
  logic busy, done;

  lpc_autocorr_if bus ();

  lpc_autocorr dut (
    .clock (clock),
    .reset (reset),
    .start (start),
    .bus   (bus.master),
    .busy  (busy),
    .done  (done)
  );

  always #5 clock = ~clock;

  logic [15:0] xs [256];
  logic [15:0] ws [256];
  logic [31:0] exp_r [11];
  logic [31:0] got_r [11];
  int total = 0;
  int bad = 0;
  int wr_cnt, done_cyc, busy_err;
  bit addr_ok;

  // Controller buffer and window ROM both answer one cycle after the address
  initial begin
    for (int i = 0; i < 256; i++) begin
      xs[i] = 16'd0;
      ws[i] = 16'd0;
    end
  end

  always @(posedge clock) begin
    bus.Mem_Sample <= xs[bus.Mem_Count];
    bus.Win_Coef   <= ws[bus.Win_Addr];
  end

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] expv);
    total++;
    assert (got === expv) else begin
      bad++;
      $error("[TB] FAIL %s got=%0h exp=%0h", tag, got, expv);
    end
  endtask

  task automatic computeExpected();
    longint yv [240];
    longint p, a;
    bit stuck;
    for (int n = 0; n < 240; n++) begin
      p = longint'($signed(xs[n])) * longint'($signed(ws[n]));
      if (xs[n] == 16'h8000 && ws[n] == 16'h8000) yv[n] = 32767;
      else yv[n] = (p + 16384) >>> 15;
    end
    for (int kk = 0; kk <= 10; kk++) begin
      a = (kk == 0) ? 1 : 0;
      stuck = 0;
      for (int n = kk; n < 240; n++) begin
        if (!stuck) begin
          a = a + 2 * yv[n] * yv[n - kk];
          if (a > 64'sd2147483647) begin a = 64'sd2147483647; stuck = 1; end
          else if (a < -64'sd2147483648) begin a = -64'sd2147483648; stuck = 1; end
        end
      end
      exp_r[kk] = 32'(a);
    end
  endtask

  task automatic fillData(input int mode);
    for (int i = 0; i < 240; i++) begin
      case (mode)
        0: begin xs[i] = 16'h0000; ws[i] = 16'h7FFF; end
        1: begin xs[i] = 16'h0100; ws[i] = 16'h7FFF; end
        2: begin xs[i] = (i == 0) ? 16'h4000 : 16'h0000; ws[i] = 16'h7FFF; end
        3: begin xs[i] = 16'h7FFF; ws[i] = 16'h7FFF; end
        4: begin xs[i] = 16'($urandom_range(0, 4095)) - 16'd2048; ws[i] = 16'($urandom); end
        default: begin xs[i] = 16'($urandom); ws[i] = 16'($urandom); end
      endcase
    end
    if (mode == 5) begin xs[7] = 16'h8000; ws[7] = 16'h8000; end
    computeExpected();
  endtask

  // Cycle numbering: the edge that samples start is cycle 0
  task automatic applyStimulus(input int inject_at, input int reset_at);
    int cyc, tail;
    wr_cnt = 0; done_cyc = -1; busy_err = 0; addr_ok = 1;
    for (int i = 0; i < 11; i++) got_r[i] = 32'hDEAD_BEEF;
    @(negedge clock); start = 1'b1;
    @(negedge clock); start = 1'b0;
    cyc = 1;
    while (cyc < 3200) begin
      if (cyc == reset_at) begin
        reset = 1'b0;
        #1;
        checkOutput("reset_mid_outputs",
                    {busy, done, bus.Acf_Write, bus.Acf_Addr, bus.Acf_Data, bus.Mem_Count, bus.Win_Addr}, 64'd0);
        tail = 0;
        repeat (3) begin @(negedge clock); tail += int'(bus.Acf_Write) + int'(done); end
        reset = 1'b1;
        repeat (30) begin @(negedge clock); tail += int'(bus.Acf_Write) + int'(done) + int'(busy); end
        checkOutput("reset_no_tail", 64'(tail), 64'd0);
        return;
      end
      if (bus.Acf_Write) begin
        if (wr_cnt < 11) begin
          got_r[wr_cnt] = bus.Acf_Data;
          if (bus.Acf_Addr != 4'(wr_cnt)) addr_ok = 0;
        end
        wr_cnt++;
      end
      if (busy !== (cyc < 2838)) busy_err++;
      if (done) done_cyc = cyc;
      start = (cyc == inject_at);
      if (done) break;
      @(negedge clock);
      cyc++;
    end
    if (inject_at == 2838) begin
      @(negedge clock);
      start = 1'b0;
      checkOutput("start_at_done_ignored", {63'd0, busy}, 64'd0);
    end
    start = 1'b0;
  endtask

  task automatic checkFrame(input string name);
    for (int kk = 0; kk <= 10; kk++)
      checkOutput($sformatf("%s_r%0d", name, kk), 64'(got_r[kk]), 64'(exp_r[kk]));
    checkOutput({name, "_write_count"}, 64'(wr_cnt), 64'd11);
    checkOutput({name, "_addr_order"}, {63'd0, addr_ok}, 64'd1);
    checkOutput({name, "_done_cycle"}, 64'(done_cyc), 64'd2838);
    checkOutput({name, "_busy_window"}, 64'(busy_err), 64'd0);
  endtask

  initial begin
    repeat (3) @(negedge clock);
    checkOutput("reset_state",
                {busy, done, bus.Acf_Write, bus.Acf_Addr, bus.Acf_Data, bus.Mem_Count, bus.Win_Addr}, 64'd0);
    reset = 1'b1;
    @(negedge clock);

    fillData(0); applyStimulus(-1, -1); checkFrame("zero");
    checkOutput("zero_r0_const", 64'(got_r[0]), 64'h0000_0001);

    fillData(1); applyStimulus(-1, -1); checkFrame("const");
    checkOutput("const_r0_const", 64'(got_r[0]), 64'h01E0_0001);
    checkOutput("const_r10_const", 64'(got_r[10]), 64'h01CC_0000);

    fillData(2); applyStimulus(-1, -1); checkFrame("impulse");
    checkOutput("impulse_r0_const", 64'(got_r[0]), 64'h2000_0001);

    fillData(3); applyStimulus(-1, -1); checkFrame("sat");
    checkOutput("sat_r5_const", 64'(got_r[5]), 64'h7FFF_FFFF);

    fillData(4); applyStimulus(100, -1); checkFrame("restart_ignored");
    applyStimulus(-1, -1); checkFrame("back_to_back");

    fillData(5); applyStimulus(2838, -1); checkFrame("fullscale");

    fillData(4); applyStimulus(-1, 1000);
    applyStimulus(-1, -1); checkFrame("after_reset");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
